dac_transmitter: RTL and testbench

Serial I2S transmitter feeding the stereo audio DAC. It captures one signed WIDTH-bit left/right sample pair per frame and shifts it out MSB-first in I2S format. Each frame has 2*WIDTH bit slots, one slot per clk cycle. It sits between the oscillator/mixer output and the DAC pins; clk is the bit clock (sys_clk/8 = 2*24*48 kHz), so one frame equals one 48 kHz sample period.

---
 rtl/dac_transmitter.sv | 65 ++++++
 tb/tb_dac_transmitter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/dac_transmitter.sv
// I2S transmitter: captures one stereo sample pair per frame and shifts it out MSB-first,
// one bit slot per clk, with the standard one-slot data delay after each word-select edge.
module dac_transmitter #(
    parameter int unsigned WIDTH = 24
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    enable,
    input  logic signed [WIDTH-1:0] left_data,
    input  logic signed [WIDTH-1:0] right_data,
    output logic                    sclk,
    output logic                    lrclk,
    output logic                    sd
);

    localparam int unsigned FrameLen = 2 * WIDTH;
    localparam int unsigned CntW     = $clog2(FrameLen);

    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [FrameLen-1:0] shreg_q, shreg_d;
    logic                sd_q, sd_d;
    logic                lrclk_q, lrclk_d;

    always_comb begin
        cnt_d   = '0;
        shreg_d = '0;
        sd_d    = 1'b0;
        lrclk_d = 1'b0;
        // Disabled: hold everything cleared so re-enable starts a fresh frame at slot 0.
        if (enable) begin
            lrclk_d = (cnt_q >= CntW'(WIDTH));
            sd_d    = shreg_q[FrameLen-1];
            if (cnt_q == '0) begin
                shreg_d = {left_data, right_data};
            end else begin
                shreg_d = shreg_q << 1;
            end
            if (cnt_q == CntW'(FrameLen - 1)) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q   <= '0;
            shreg_q <= '0;
            sd_q    <= 1'b0;
            lrclk_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            sd_q    <= sd_d;
            lrclk_q <= lrclk_d;
        end
    end

    // DAC samples on sclk rising, i.e. mid-slot on the clk falling edge.
    assign sclk  = ~clk & rstn & enable;
    assign sd    = sd_q;
    assign lrclk = lrclk_q;

endmodule

// File: tb/tb_dac_transmitter.sv
// Directed bench for dac_transmitter: table-driven full frames at WIDTH=24 plus hand-written
// reset, disable and WIDTH=8 sequences.
module tb_dac_transmitter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        enable;
    logic [23:0] left_data, right_data;
    logic        sclk, lrclk, sd;

    logic        enable8;
    logic [7:0]  left8, right8;
    logic        sclk8, lrclk8, sd8;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    dac_transmitter #(.WIDTH(24)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .enable     (enable),
        .left_data  (left_data),
        .right_data (right_data),
        .sclk       (sclk),
        .lrclk      (lrclk),
        .sd         (sd)
    );

    dac_transmitter #(.WIDTH(8)) dut8 (
        .clk        (clk),
        .rstn       (rstn),
        .enable     (enable8),
        .left_data  (left8),
        .right_data (right8),
        .sclk       (sclk8),
        .lrclk      (lrclk8),
        .sd         (sd8)
    );

    typedef struct {
        logic [23:0] left;
        logic [23:0] right;
        logic [47:0] exp_sd;   // sd for slots 1..47 then next slot 0
    } vec_t;

    localparam int NV = 4;
    localparam logic [47:0] LrExp24 = 48'h000001FFFFFE;

    vec_t vecs [NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic collect48(output logic [47:0] sdv, output logic [47:0] lrv);
        sdv = '0;
        lrv = '0;
        for (int i = 0; i < 48; i++) begin
            step();
            sdv[47-i] = sd;
            lrv[47-i] = lrclk;
        end
    endtask

    logic [47:0] sd_a, lr_a;
    logic [24:0] sd25, lr25;
    logic [15:0] sd16, lr16;
    logic        any_set;

    initial begin
        vecs[0] = '{24'hABCDEF, 24'h123456, 48'hABCDEF123456};
        vecs[1] = '{24'h800000, 24'h7FFFFF, 48'h8000007FFFFF};
        vecs[2] = '{24'h5A5A5A, 24'hA5A5A5, 48'h5A5A5AA5A5A5};
        vecs[3] = '{24'hFFFFFF, 24'h000000, 48'hFFFFFF000000};

        rstn = 1'b0;
        enable = 1'b0;
        enable8 = 1'b0;
        left_data = '0;
        right_data = '0;
        left8 = '0;
        right8 = '0;
        #1;
        check("reset_outputs", {61'd0, sd, lrclk, sclk}, 64'd0);
        repeat (3) step();
        check("reset_held", {61'd0, sd, lrclk, sclk}, 64'd0);

        @(negedge clk);
        rstn = 1'b1;
        #1;
        check("sclk_gated_disabled", {63'd0, sclk}, 64'd0);
        enable = 1'b1;
        left_data = vecs[0].left;
        right_data = vecs[0].right;
        #1;
        check("sclk_running", {63'd0, sclk}, 64'd1);

        step();
        check("first_slot0", {62'd0, sd, lrclk}, 64'd0);

        // Each frame also scrambles the inputs at slot 10 to prove they are ignored mid-frame.
        for (int v = 0; v < NV; v++) begin
            sd_a = '0;
            lr_a = '0;
            for (int i = 0; i < 48; i++) begin
                step();
                sd_a[47-i] = sd;
                lr_a[47-i] = lrclk;
                if (i == 9) begin
                    left_data = ~left_data;
                    right_data = ~right_data;
                end
                if (i == 46 && v + 1 < NV) begin
                    left_data = vecs[v+1].left;
                    right_data = vecs[v+1].right;
                end
            end
            check($sformatf("vec%0d_sd", v), {16'd0, sd_a}, {16'd0, vecs[v].exp_sd});
            check($sformatf("vec%0d_lrclk", v), {16'd0, lr_a}, {16'd0, LrExp24});
        end

        // Captured frame is now left=000000, right=FFFFFF; slot 30 carries right bit 18 = 1.
        repeat (30) step();
        check("slot30_pre_reset", {62'd0, sd, lrclk}, 64'd3);
        @(negedge clk);
        check("slot30_sclk", {63'd0, sclk}, 64'd1);
        rstn = 1'b0;
        #1;
        check("async_reset_immediate", {61'd0, sd, lrclk, sclk}, 64'd0);
        left_data = 24'hC3A517;
        right_data = 24'h000000;
        repeat (2) step();
        check("reset_mid_hold", {61'd0, sd, lrclk, sclk}, 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        sd25 = '0;
        lr25 = '0;
        for (int e = 0; e < 25; e++) begin
            step();
            sd25[24-e] = sd;
            lr25[24-e] = lrclk;
        end
        check("post_reset_sd", {39'd0, sd25}, {39'd0, 1'b0, 24'hC3A517});
        check("post_reset_lrclk", {39'd0, lr25}, 64'd1);

        repeat (2) step();
        check("pre_disable_lrclk", {63'd0, lrclk}, 64'd1);
        @(negedge clk);
        enable = 1'b0;
        #1;
        check("disable_sclk_held", {63'd0, sclk}, 64'd0);
        any_set = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            any_set = any_set | sd | lrclk | sclk;
        end
        check("disabled_outputs", {63'd0, any_set}, 64'd0);
        @(negedge clk);
        enable = 1'b1;
        left_data = 24'h0F0F0F;
        right_data = 24'hF0F0F0;
        step();
        check("reenable_slot0", {62'd0, sd, lrclk}, 64'd0);
        collect48(sd_a, lr_a);
        check("reenable_frame_sd", {16'd0, sd_a}, {16'd0, 48'h0F0F0FF0F0F0});
        check("reenable_frame_lrclk", {16'd0, lr_a}, {16'd0, LrExp24});

        @(negedge clk);
        enable8 = 1'b1;
        left8 = 8'hA5;
        right8 = 8'h3C;
        step();
        check("w8_slot0", {62'd0, sd8, lrclk8}, 64'd0);
        sd16 = '0;
        lr16 = '0;
        for (int i = 0; i < 16; i++) begin
            step();
            sd16[15-i] = sd8;
            lr16[15-i] = lrclk8;
        end
        check("w8_frame_sd", {48'd0, sd16}, {48'd0, 16'hA53C});
        check("w8_frame_lrclk", {48'd0, lr16}, {48'd0, 16'h01FE});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
